// File: rtl/sensor_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sensor_responder                                                           |
// | Polled-UART sensor node: decodes a poll byte and replies data + CRC-8.     |
// | Optional: SENSOR_RESPONDER_FAULT_INJECT_EN adds a fault_inject port.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module sensor_responder #(
    parameter int         ADDR       = 1,
    parameter int         TURNAROUND = 16,
    parameter logic [7:0] CRC_POLY   = 8'h07
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_rdy,
    output logic       rx_rdy_clr,
    output logic [7:0] tx_din,
    output logic       tx_wr_en,
    input  logic       tx_busy,
    input  logic [7:0] sample,
    input  logic       alarm_in,
    output logic       alarm_latched,
`ifdef SENSOR_RESPONDER_FAULT_INJECT_EN
    input  logic       fault_inject,
`endif
    output logic       busy
);

    localparam int                 c_cnt_w     = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam logic [c_cnt_w-1:0] c_turn_last = c_cnt_w'(TURNAROUND - 1);
    localparam logic [2:0]         c_addr      = 3'(ADDR);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_TURN      = 3'd2,
        S_SEND_DATA = 3'd3,
        S_WAIT_DATA = 3'd4,
        S_SEND_CRC  = 3'd5,
        S_WAIT_CRC  = 3'd6
    } state_t;

    state_t             r_state;
    logic [2:0]         r_addr;
    logic [c_cnt_w-1:0] r_cnt;
    logic [7:0]         r_dhold;
    logic [7:0]         r_chold;
    logic               r_seen_busy;

    logic [7:0]         w_crc;
    logic [7:0]         w_fault_mask;
    logic [7:0]         w_chold;
    logic               w_unused_rx_hi;

    function automatic logic [7:0] crc8(input logic [7:0] d);
        logic [7:0] c;
        c = d;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

`ifdef SENSOR_RESPONDER_FAULT_INJECT_EN
    assign w_fault_mask = fault_inject ? 8'h01 : 8'h00;
`else
    assign w_fault_mask = 8'h00;
`endif

    // An inverted CRC marks an alarm frame rather than a corrupt one.
    assign w_crc          = crc8(sample);
    assign w_chold        = w_crc ^ {8{alarm_latched}} ^ w_fault_mask;
    assign w_unused_rx_hi = ^rx_data[7:3];
    assign busy           = (r_state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_addr        <= 3'd0;
            r_cnt         <= '0;
            r_dhold       <= 8'h00;
            r_chold       <= 8'h00;
            r_seen_busy   <= 1'b0;
            rx_rdy_clr    <= 1'b0;
            tx_din        <= 8'h00;
            tx_wr_en      <= 1'b0;
            alarm_latched <= 1'b0;
        end else begin
            rx_rdy_clr <= 1'b0;
            tx_wr_en   <= 1'b0;

            if (alarm_in) begin
                alarm_latched <= 1'b1;
            end else if (r_state == S_DECODE && r_addr == 3'd0) begin
                alarm_latched <= 1'b0;
            end

            // Bytes arriving mid-reply are acknowledged and dropped.
            if (r_state != S_IDLE) begin
                rx_rdy_clr <= rx_rdy & ~rx_rdy_clr;
            end

            case (r_state)
                S_IDLE: begin
                    if (rx_rdy && !rx_rdy_clr) begin
                        rx_rdy_clr <= 1'b1;
                        r_addr     <= rx_data[2:0];
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (r_addr == c_addr) begin
                        r_dhold <= sample;
                        r_chold <= w_chold;
                        r_cnt   <= '0;
                        r_state <= S_TURN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_TURN: begin
                    // The last turnaround cycle issues the data byte directly so
                    // the first write lands exactly TURNAROUND cycles after decode.
                    if (r_cnt == c_turn_last) begin
                        if (!tx_busy) begin
                            tx_din   <= r_dhold;
                            tx_wr_en <= 1'b1;
                            r_state  <= S_WAIT_DATA;
                        end else begin
                            r_state  <= S_SEND_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SEND_DATA: begin
                    if (!tx_busy) begin
                        tx_din   <= r_dhold;
                        tx_wr_en <= 1'b1;
                        r_state  <= S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    if (tx_busy) begin
                        r_seen_busy <= 1'b1;
                    end else if (r_seen_busy) begin
                        r_seen_busy <= 1'b0;
                        r_state     <= S_SEND_CRC;
                    end
                end
                S_SEND_CRC: begin
                    if (!tx_busy) begin
                        tx_din   <= r_chold;
                        tx_wr_en <= 1'b1;
                        r_state  <= S_WAIT_CRC;
                    end
                end
                S_WAIT_CRC: begin
                    if (tx_busy) begin
                        r_seen_busy <= 1'b1;
                    end else if (r_seen_busy) begin
                        r_seen_busy <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sensor_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sensor_responder                                                        |
// | Directed bench for sensor_responder with a small UART rx/tx model.         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_sensor_responder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rdy = 1'b0;
    logic       rx_rdy_clr;
    logic [7:0] tx_din;
    logic       tx_wr_en;
    logic       tx_busy = 1'b0;
    logic [7:0] sample = 8'h00;
    logic       alarm_in = 1'b0;
    logic       alarm_latched;
    logic       busy;
`ifdef SENSOR_RESPONDER_FAULT_INJECT_EN
    logic       fault_inject = 1'b0;
`endif

    sensor_responder #(.ADDR(1), .TURNAROUND(16), .CRC_POLY(8'h07)) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_rdy        (rx_rdy),
        .rx_rdy_clr    (rx_rdy_clr),
        .tx_din        (tx_din),
        .tx_wr_en      (tx_wr_en),
        .tx_busy       (tx_busy),
        .sample        (sample),
        .alarm_in      (alarm_in),
        .alarm_latched (alarm_latched),
`ifdef SENSOR_RESPONDER_FAULT_INJECT_EN
        .fault_inject  (fault_inject),
`endif
        .busy          (busy)
    );

    always #5 clock = ~clock;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         t_poll = 0;
    int         first_wr_cyc = 0;
    int         n_clr = 0;
    int         busy_cnt = 0;
    logic       force_busy = 1'b0;
    logic       s_clr, s_wr, s_busy;
    logic [7:0] s_din;
    logic [7:0] txq[$];

    typedef struct {
        logic [7:0] poll;
        logic [7:0] smp;
        logic       pre_alarm;
        int         n_tx;
        logic [7:0] exp_d;
        logic [7:0] exp_c;
        logic       exp_alarm;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Sample mid-cycle, then advance one edge and update the UART model.
    task automatic tick();
        @(negedge clock);
        s_clr  = rx_rdy_clr;
        s_wr   = tx_wr_en;
        s_din  = tx_din;
        s_busy = busy;
        if (s_clr) n_clr++;
        if (s_wr) begin
            if (txq.size() == 0) first_wr_cyc = cyc;
            txq.push_back(s_din);
        end
        @(posedge clock);
        #1;
        cyc++;
        if (s_clr) rx_rdy = 1'b0;
        if (s_wr) busy_cnt = 3;
        else if (busy_cnt > 0) busy_cnt--;
        tx_busy = force_busy || (busy_cnt > 0);
    endtask

    task automatic poll(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        t_poll  = cyc;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!(k >= 3 && s_busy == 1'b0 && rx_rdy == 1'b0 && busy_cnt == 0) && k < budget);
        chk({tag, " idle timeout"}, 32'(k < budget), 32'd1);
    endtask

    task automatic pulse_alarm();
        alarm_in = 1'b1;
        tick();
        alarm_in = 1'b0;
        chk("alarm latch set", 32'(alarm_latched), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int k;
        vecs[0]  = '{8'h01, 8'h03, 1'b0, 2, 8'h03, 8'h09, 1'b0};
        vecs[1]  = '{8'h01, 8'h80, 1'b0, 2, 8'h80, 8'h89, 1'b0};
        vecs[2]  = '{8'h01, 8'h03, 1'b1, 2, 8'h03, 8'hF6, 1'b1};
        vecs[3]  = '{8'h00, 8'h03, 1'b0, 0, 8'h00, 8'h00, 1'b0};
        vecs[4]  = '{8'h02, 8'h03, 1'b0, 0, 8'h00, 8'h00, 1'b0};
        vecs[5]  = '{8'hF9, 8'h03, 1'b0, 2, 8'h03, 8'h09, 1'b0};
        vecs[6]  = '{8'h0D, 8'h03, 1'b0, 0, 8'h00, 8'h00, 1'b0};
        vecs[7]  = '{8'h08, 8'h03, 1'b1, 0, 8'h00, 8'h00, 1'b0};
        vecs[8]  = '{8'h01, 8'h00, 1'b0, 2, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{8'h01, 8'hFF, 1'b1, 2, 8'hFF, 8'h0C, 1'b1};
        vecs[10] = '{8'h00, 8'hFF, 1'b0, 0, 8'h00, 8'h00, 1'b0};

        // Reset state
        repeat (3) tick();
        chk("reset outputs", {19'd0, rx_rdy_clr, tx_wr_en, tx_din, alarm_latched, busy}, 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Table-driven polls
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].pre_alarm) pulse_alarm();
            sample = vecs[i].smp;
            txq.delete();
            n_clr = 0;
            poll(vecs[i].poll);
            wait_idle(150, $sformatf("vec%0d", i));
            repeat (5) tick();
            chk($sformatf("vec%0d rx_rdy_clr count", i), 32'(n_clr), 32'd1);
            chk($sformatf("vec%0d tx count", i), 32'(txq.size()), 32'(vecs[i].n_tx));
            if (vecs[i].n_tx == 2 && txq.size() == 2) begin
                chk($sformatf("vec%0d data byte", i), 32'(txq[0]), 32'(vecs[i].exp_d));
                chk($sformatf("vec%0d crc byte", i), 32'(txq[1]), 32'(vecs[i].exp_c));
            end
            chk($sformatf("vec%0d alarm_latched", i), 32'(alarm_latched), 32'(vecs[i].exp_alarm));
            if (i == 0) chk("first tx latency", 32'(first_wr_cyc - t_poll), 32'd18);
        end

        // tx_busy held through SEND_DATA, then a poll injected during WAIT_CRC
        sample = 8'h03;
        txq.delete();
        n_clr = 0;
        force_busy = 1'b1;
        tx_busy = 1'b1;
        poll(8'h01);
        repeat (58) tick();
        chk("held busy: no tx", 32'(txq.size()), 32'd0);
        chk("held busy: busy flag", 32'(s_busy), 32'd1);
        force_busy = 1'b0;
        tx_busy = (busy_cnt > 0);
        k = cyc;
        for (int j = 0; j < 20 && txq.size() < 1; j++) tick();
        chk("release: data issued", 32'(txq.size()), 32'd1);
        chk("release: write latency", 32'(first_wr_cyc - k), 32'd1);
        for (int j = 0; j < 40 && txq.size() < 2; j++) tick();
        chk("release: crc issued", 32'(txq.size()), 32'd2);
        poll(8'h01);
        wait_idle(60, "inject");
        repeat (40) tick();
        chk("inject: clr count", 32'(n_clr), 32'd2);
        chk("inject: no second reply", 32'(txq.size()), 32'd2);
        if (txq.size() >= 2) chk("inject: bytes", {16'd0, txq[0], txq[1]}, 32'h0309);

        // Reset during WAIT_DATA of an alarm frame
        pulse_alarm();
        txq.delete();
        n_clr = 0;
        poll(8'h01);
        for (int j = 0; j < 40 && txq.size() < 1; j++) tick();
        chk("reset test: data issued", 32'(txq.size()), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid-reply reset outputs", {19'd0, rx_rdy_clr, tx_wr_en, tx_din, alarm_latched, busy}, 32'd0);
        reset = 1'b0;
        repeat (30) tick();
        chk("reset test: no crc byte", 32'(txq.size()), 32'd1);
        txq.delete();
        poll(8'h01);
        wait_idle(150, "post-reset");
        chk("post-reset reply", (txq.size() == 2) ? {16'd0, txq[0], txq[1]} : 32'hDEAD, 32'h0309);

`ifdef SENSOR_RESPONDER_FAULT_INJECT_EN
        sample = 8'h80;
        fault_inject = 1'b1;
        txq.delete();
        poll(8'h01);
        wait_idle(150, "fault");
        fault_inject = 1'b0;
        chk("fault inject reply", (txq.size() == 2) ? {16'd0, txq[0], txq[1]} : 32'hDEAD, 32'h8088);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sensor_responder.md
Name: sensor_responder

Overview:
- Sensor-node side of the polled UART link: the stage directly upstream of the bus arbitrator, producing the frames it consumes.
- Receives one poll byte from a byte-level UART and decodes the 3-bit sensor address.
- When addressed, captures the local sample and replies with two bytes: data, then CRC-8.
- A latched alarm changes the reply to an alarm frame. Address 0 is a broadcast alarm acknowledge and gets no reply.

Parameters:
- ADDR, 3'd1: this node's sensor address, legal range 1..5.
- TURNAROUND, 16: idle cycles between poll decode and the first tx_wr_en. Minimum 1.
- CRC_POLY, 8'h07: CRC-8 polynomial; MSB-first, init 8'h00, no final XOR.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- rx_data, input, 8: received byte from the UART.
- rx_rdy, input, 1: rx_data valid; held high until cleared.
- rx_rdy_clr, output, 1: one-cycle pulse acknowledging rx_data.
- tx_din, output, 8: byte to transmit.
- tx_wr_en, output, 1: one-cycle transmit request.
- tx_busy, input, 1: UART transmitter busy.
- sample, input, 8: live sensor value.
- alarm_in, input, 1: alarm event; level or pulse, latched internally.
- alarm_latched, output, 1: sticky alarm flag.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset values:
  - Outputs: rx_rdy_clr=0, tx_wr_en=0, tx_din=8'h00, alarm_latched=0, busy=0.
  - Internal: state=IDLE, turnaround counter=0, holding registers=0.
  - Reset mid-reply abandons the frame immediately; no further tx_wr_en is issued.
- Alarm latch:
  - Set on any cycle with alarm_in=1.
  - Cleared only by reset or by a broadcast poll (rx_data[2:0]==0).
  - If set and clear occur in the same cycle, set wins.
- Only rx_data[2:0] is decoded; bits [7:3] are ignored.
- IDLE:
  - On rx_rdy=1, pulse rx_rdy_clr for 1 cycle and register rx_data[2:0]. Go to DECODE.
- DECODE (1 cycle):
  - addr==0: clear the alarm latch, go to IDLE.
  - addr==ADDR: capture sample into dhold and compute the CRC over dhold, all in this cycle. Go to TURN.
    - If the alarm latch is set, chold = ~CRC8(dhold); otherwise chold = CRC8(dhold).
  - Any other address: go to IDLE.
- TURN:
  - Count TURNAROUND cycles, then go to SEND_DATA.
- SEND_DATA:
  - When tx_busy=0: tx_din=dhold, pulse tx_wr_en for exactly 1 cycle, go to WAIT_DATA.
- WAIT_DATA:
  - Wait until tx_busy has been seen 1, then wait until tx_busy=0. Go to SEND_CRC.
- SEND_CRC:
  - Same as SEND_DATA, using chold. Go to WAIT_CRC.
- WAIT_CRC:
  - Same as WAIT_DATA. Go to IDLE.
- Bytes arriving while busy=1:
  - Consumed and discarded: rx_rdy_clr pulses on the next cycle with rx_rdy=1.
  - No second reply is queued.
- Latency: poll rx_rdy to first tx_wr_en = 2 + TURNAROUND cycles, when tx_busy=0.
- tx_din holds its value from the tx_wr_en cycle until the next tx_wr_en.
- Alarm frame encoding: the CRC byte is the bitwise inverse of the correct CRC. The arbitrator's checker classifies it as an alarm, not as a CRC error.

Optional Feature:
- Macro: SENSOR_RESPONDER_FAULT_INJECT_EN.
- When defined:
  - Adds input port fault_inject (1 bit).
  - If fault_inject=1 in the DECODE cycle, chold is additionally XORed with 8'h01, producing a deliberate CRC error.
- When undefined:
  - The port is absent and chold is never corrupted.

Test Plan:
1. ADDR=1, sample=8'h03, poll 8'h01, no alarm -> tx bytes 8'h03 then 8'h09; first tx_wr_en exactly 18 cycles after the rx_rdy cycle.
2. Latch alarm, sample=8'h03, poll 8'h01 -> reply 8'h03, 8'hF6; alarm_latched stays 1. Then poll 8'h00 -> no tx, alarm_latched=0.
3. Poll 8'h02 and poll 8'hF9 to a node with ADDR=1 -> rx_rdy_clr pulses once each; no tx_wr_en; second poll (addr 1) gets reply 8'h03/8'h09.
4. Hold tx_busy=1 for 40 cycles during SEND_DATA, and inject a poll during WAIT_CRC -> tx_wr_en waits for tx_busy=0; the injected byte is cleared and no second reply is sent.
5. Assert reset in WAIT_DATA -> all outputs return to reset values next cycle; no CRC byte is sent; the next poll gets a normal reply.
6. With SENSOR_RESPONDER_FAULT_INJECT_EN, sample=8'h80, fault_inject=1 -> reply 8'h80, 8'h88 (correct CRC would be 8'h89).
